// File: rtl/pll_dyn_ctrl.sv
// Divider-preset sequencer for a runtime-reconfigurable PLL: debounced key picks preset A/B,
// then the PLL is reset, lock is qualified, and failed attempts are retried a bounded number of times.
module pll_dyn_ctrl #(
  parameter int unsigned FDIV_A       = 9,
  parameter int unsigned IDIV_A       = 2,
  parameter int unsigned FDIV_B       = 12,
  parameter int unsigned IDIV_B       = 5,
  parameter int unsigned DEB_CYCLES   = 65536,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       lock,
  output logic [5:0] fdiv,
  output logic [5:0] idiv,
  output logic       pll_reset,
  output logic       cur_sel,
  output logic       busy,
  output logic       locked,
  output logic       err
);

  localparam int unsigned DW  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned TW  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0]  DEB_LIM   = DW'(DEB_CYCLES);
  localparam logic [RCW-1:0] RST_LIM   = RCW'(RST_CYCLES);
  localparam logic [TW-1:0]  TMO_LIM   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0]  STB_LIM   = SW'(LOCK_STABLE);
  localparam logic [RW-1:0]  RETRY_LIM = RW'(MAX_RETRY);

  // The PLL primitive takes its dividers in inverted encoding.
  localparam logic [5:0] FDIV_A_ENC = ~6'(FDIV_A);
  localparam logic [5:0] IDIV_A_ENC = ~6'(IDIV_A);
  localparam logic [5:0] FDIV_B_ENC = ~6'(FDIV_B);
  localparam logic [5:0] IDIV_B_ENC = ~6'(IDIV_B);

  typedef enum logic [2:0] {IDLE, APPLY, RESET, WAIT_LOCK, FAIL} state_t;

  state_t          state, state_next;
  logic            key_meta, key_sync, lock_meta, lock_sync;
  logic            key_deb, fail_key;
  logic [DW-1:0]   deb_cnt;
  logic [RCW-1:0]  rst_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [SW-1:0]   stb_cnt;
  logic [RW-1:0]   retry_cnt;
  logic            rst_done, lock_hit, tmo_hit;

  // Two-flop synchronisers, then a key debouncer that only commits after a long stable run.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta  <= 1'b0;
      key_sync  <= 1'b0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      key_deb   <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      key_meta  <= key;
      key_sync  <= key_meta;
      lock_meta <= lock;
      lock_sync <= lock_meta;
      if (key_sync != key_deb) begin
        if (deb_cnt + DW'(1) == DEB_LIM) begin
          key_deb <= key_sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Next-state logic; a pending preset request takes priority over a lock loss in IDLE.
  always_comb begin
    state_next = state;
    rst_done   = (rst_cnt + RCW'(1) == RST_LIM);
    lock_hit   = lock_sync && (stb_cnt + SW'(1) == STB_LIM);
    tmo_hit    = (tmo_cnt + TW'(1) == TMO_LIM);
    case (state)
      IDLE: begin
        if (key_deb != cur_sel)
          state_next = APPLY;
        else if (!lock_sync)
          state_next = RESET;
      end
      APPLY:     state_next = RESET;
      RESET:     if (rst_done) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_hit)
          state_next = IDLE;
        else if (tmo_hit)
          state_next = (retry_cnt < RETRY_LIM) ? RESET : FAIL;
      end
      FAIL:      if (key_deb != fail_key) state_next = APPLY;
      default:   state_next = RESET;
    endcase
    pll_reset = (state == RESET);
    busy      = (state != IDLE) && (state != FAIL);
    locked    = (state == IDLE);
    err       = (state == FAIL);
  end

  // State register plus the per-state counters, retry bookkeeping and the applied preset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET;
      cur_sel   <= 1'b0;
      fdiv      <= FDIV_A_ENC;
      idiv      <= IDIV_A_ENC;
      rst_cnt   <= '0;
      tmo_cnt   <= '0;
      stb_cnt   <= '0;
      retry_cnt <= '0;
      fail_key  <= 1'b0;
    end else begin
      state   <= state_next;
      rst_cnt <= (state == RESET && state_next == RESET) ? rst_cnt + RCW'(1) : '0;
      if (state == WAIT_LOCK && state_next == WAIT_LOCK) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        stb_cnt <= lock_sync ? stb_cnt + SW'(1) : '0;
      end else begin
        tmo_cnt <= '0;
        stb_cnt <= '0;
      end
      if (state == APPLY) begin
        cur_sel <= key_deb;
        fdiv    <= key_deb ? FDIV_B_ENC : FDIV_A_ENC;
        idiv    <= key_deb ? IDIV_B_ENC : IDIV_A_ENC;
      end
      if (state == APPLY || (state == IDLE && state_next == RESET))
        retry_cnt <= '0;
      else if (state == WAIT_LOCK && state_next == RESET)
        retry_cnt <= retry_cnt + RW'(1);
      // Remember the key level at FAIL entry so only a fresh toggle restarts.
      if (state_next == FAIL && state != FAIL)
        fail_key <= key_deb;
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl: settled-status expectations are queued as stimulus is
// driven and popped when the DUT reports lock or error; pulse widths and latencies are timed directly.
module tb_pll_dyn_ctrl;

  localparam int LOCK_DELAY = 20;
  localparam logic [5:0] F_A = 6'b110110;
  localparam logic [5:0] I_A = 6'b111101;
  localparam logic [5:0] F_B = 6'b110011;
  localparam logic [5:0] I_B = 6'b111010;

  localparam int SIG_SEL    = 0;
  localparam int SIG_PRST   = 1;
  localparam int SIG_LOCKED = 2;
  localparam int SIG_ERR    = 3;
  localparam int SIG_LOCK   = 4;

  typedef struct {
    string      tag;
    logic       sel;
    logic [5:0] f;
    logic [5:0] i;
    logic       lk;
    logic       bz;
    logic       er;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       key;
  logic       lock;
  logic [5:0] fdiv;
  logic [5:0] idiv;
  logic       pll_reset;
  logic       cur_sel;
  logic       busy;
  logic       locked;
  logic       err;

  int   checks;
  int   errors;
  int   lk_cnt;
  logic lock_hold_low;
  time  drop_end;
  exp_t sbq[$];

  pll_dyn_ctrl #(
    .DEB_CYCLES  (4),
    .RST_CYCLES  (8),
    .LOCK_STABLE (4),
    .LOCK_TIMEOUT(64),
    .MAX_RETRY   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .lock     (lock),
    .fdiv     (fdiv),
    .idiv     (idiv),
    .pll_reset(pll_reset),
    .cur_sel  (cur_sel),
    .busy     (busy),
    .locked   (locked),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PLL model: lock drops under reset, forced-low or drop windows, and rises LOCK_DELAY cycles later.
  initial begin
    lock   = 1'b0;
    lk_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (pll_reset !== 1'b0 || lock_hold_low || $time < drop_end) begin
        lock   = 1'b0;
        lk_cnt = 0;
      end else begin
        if (lk_cnt < LOCK_DELAY) lk_cnt++;
        lock = (lk_cnt >= LOCK_DELAY);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic level, input int hold);
    key = level;
    if (hold > 0) begin
      fork
        begin
          repeat (hold) @(negedge clk);
          key = ~level;
        end
      join_none
    end
  endtask

  function automatic logic getSig(input int id);
    case (id)
      SIG_SEL:    return cur_sel;
      SIG_PRST:   return pll_reset;
      SIG_LOCKED: return locked;
      SIG_ERR:    return err;
      default:    return lock;
    endcase
  endfunction

  task automatic waitFor(input int id, input logic val, input int limit, input string tag);
    for (int i = 0; i < limit && getSig(id) !== val; i++) @(negedge clk);
    checkOutput({tag, ".reached"}, getSig(id), val);
  endtask

  task automatic pushExp(input string tag, input logic sel, input logic lk, input logic bz, input logic er);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.f   = sel ? F_B : F_A;
    e.i   = sel ? I_B : I_A;
    e.lk  = lk;
    e.bz  = bz;
    e.er  = er;
    sbq.push_back(e);
  endtask

  task automatic popAndCompare(input int id, input int limit);
    exp_t e;
    waitFor(id, 1'b1, limit, "settle");
    checkOutput("sb_nonempty", sbq.size() != 0, 1'b1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput({e.tag, ".cur_sel"}, cur_sel, e.sel);
      checkOutput({e.tag, ".fdiv"}, fdiv, e.f);
      checkOutput({e.tag, ".idiv"}, idiv, e.i);
      checkOutput({e.tag, ".locked"}, locked, e.lk);
      checkOutput({e.tag, ".busy"}, busy, e.bz);
      checkOutput({e.tag, ".err"}, err, e.er);
    end
  endtask

  task automatic measurePulse(output int n);
    n = 0;
    while (pll_reset === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic countWait(output int n);
    n = 0;
    while (pll_reset === 1'b0 && err === 1'b0 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int   n;
    logic any_busy, any_prst, any_sel, any_div;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    key           = 1'b0;
    lock_hold_low = 1'b0;
    drop_end      = 0;

    // Power-up
    repeat (3) @(negedge clk);
    checkOutput("rst.fdiv", fdiv, F_A);
    checkOutput("rst.idiv", idiv, I_A);
    checkOutput("rst.cur_sel", cur_sel, 1'b0);
    checkOutput("rst.pll_reset", pll_reset, 1'b1);
    checkOutput("rst.busy", busy, 1'b1);
    checkOutput("rst.locked", locked, 1'b0);
    checkOutput("rst.err", err, 1'b0);
    pushExp("powerup", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    measurePulse(n);
    checkOutput("powerup.pll_reset_len", n, 8);
    waitFor(SIG_LOCK, 1'b1, 100, "powerup.lock");
    repeat (5) @(negedge clk);
    checkOutput("powerup.locked_early", locked, 1'b0);
    @(negedge clk);
    checkOutput("powerup.locked_latency", locked, 1'b1);
    popAndCompare(SIG_LOCKED, 10);

    // Key press held 10 cycles: preset B, then release returns to A
    pushExp("preset_b", 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp("preset_a", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 10);
    waitFor(SIG_SEL, 1'b1, 40, "press.apply");
    checkOutput("press.fdiv", fdiv, F_B);
    checkOutput("press.idiv", idiv, I_B);
    measurePulse(n);
    checkOutput("press.pll_reset_len", n, 8);
    popAndCompare(SIG_LOCKED, 200);
    waitFor(SIG_SEL, 1'b0, 20, "release.apply");
    checkOutput("release.fdiv", fdiv, F_A);
    checkOutput("release.idiv", idiv, I_A);
    measurePulse(n);
    checkOutput("release.pll_reset_len", n, 8);
    popAndCompare(SIG_LOCKED, 200);

    // 3-cycle glitch must be ignored
    any_busy = 1'b0;
    any_prst = 1'b0;
    any_sel  = 1'b0;
    any_div  = 1'b0;
    applyStimulus(1'b1, 3);
    repeat (20) begin
      @(negedge clk);
      any_busy = any_busy | busy;
      any_prst = any_prst | pll_reset;
      any_sel  = any_sel | cur_sel;
      any_div  = any_div | (fdiv !== F_A) | (idiv !== I_A);
    end
    checkOutput("glitch.busy", any_busy, 1'b0);
    checkOutput("glitch.pll_reset", any_prst, 1'b0);
    checkOutput("glitch.cur_sel", any_sel, 1'b0);
    checkOutput("glitch.div_changed", any_div, 1'b0);

    // Lock never returns: three attempts then FAIL
    pushExp("fail", 1'b0, 1'b0, 1'b0, 1'b1);
    lock_hold_low = 1'b1;
    for (int a = 0; a < 3; a++) begin
      waitFor(SIG_PRST, 1'b1, 40, $sformatf("retry%0d.start", a));
      measurePulse(n);
      checkOutput($sformatf("retry%0d.pll_reset_len", a), n, 8);
      countWait(n);
      checkOutput($sformatf("retry%0d.wait_len", a), n, 64);
    end
    popAndCompare(SIG_ERR, 5);
    lock_hold_low = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("fail.sticky_err", err, 1'b1);
    checkOutput("fail.sticky_busy", busy, 1'b0);
    checkOutput("fail.sticky_pll_reset", pll_reset, 1'b0);

    // Key toggle leaves FAIL through APPLY
    pushExp("fail_exit", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 0);
    waitFor(SIG_SEL, 1'b1, 40, "fail_exit.apply");
    checkOutput("fail_exit.err", err, 1'b0);
    checkOutput("fail_exit.busy", busy, 1'b1);
    checkOutput("fail_exit.fdiv", fdiv, F_B);
    measurePulse(n);
    checkOutput("fail_exit.pll_reset_len", n, 8);
    popAndCompare(SIG_LOCKED, 200);

    // Lock dropped 5 cycles while IDLE
    pushExp("lock_drop", 1'b1, 1'b1, 1'b0, 1'b0);
    drop_end = $time + 50;
    waitFor(SIG_LOCKED, 1'b0, 20, "drop.unlock");
    checkOutput("drop.cur_sel", cur_sel, 1'b1);
    checkOutput("drop.fdiv", fdiv, F_B);
    measurePulse(n);
    checkOutput("drop.pll_reset_len", n, 8);
    popAndCompare(SIG_LOCKED, 200);

    // Key released during WAIT_LOCK, then rst asserted in the following RESET
    pushExp("no_abort", 1'b1, 1'b1, 1'b0, 1'b0);
    drop_end = $time + 50;
    waitFor(SIG_PRST, 1'b1, 30, "no_abort.reset");
    measurePulse(n);
    checkOutput("no_abort.pll_reset_len", n, 8);
    applyStimulus(1'b0, 0);
    popAndCompare(SIG_LOCKED, 200);
    waitFor(SIG_SEL, 1'b0, 20, "no_abort.apply");
    checkOutput("no_abort.fdiv", fdiv, F_A);
    repeat (3) @(negedge clk);
    pushExp("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst.fdiv", fdiv, F_A);
    checkOutput("midrst.idiv", idiv, I_A);
    checkOutput("midrst.cur_sel", cur_sel, 1'b0);
    checkOutput("midrst.pll_reset", pll_reset, 1'b1);
    checkOutput("midrst.busy", busy, 1'b1);
    checkOutput("midrst.locked", locked, 1'b0);
    checkOutput("midrst.err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    measurePulse(n);
    checkOutput("midrst.pll_reset_len", n, 8);
    popAndCompare(SIG_LOCKED, 200);
    checkOutput("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
